tree_adder: RTL and testbench
=============================

Name: tree_adder

Overview:
- Pipelined, parameterised reduction adder: sums SIZE unsigned WIDTH-bit lanes, result modulo 2^WIDTH.
- Binary adder tree, one register stage per tree level; accepts a new vector every cycle.
- Sits in datapath reduction logic (accumulators, dot-product tails); no backpressure.

Parameters:
- WIDTH, 8, bit width of each lane and of the result.
- SIZE, 4, number of input lanes (≥1; any integer, not limited to powers of two).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  data_in holds a vector to be summed this cycle.
- data_in  input  WIDTH*SIZE  packed lanes; lane i = data_in[i*WIDTH +: WIDTH], lane 0 at LSBs.
- out_valid  output  1  data_out holds a completed sum.
- data_out  output  WIDTH  sum of all lanes mod 2^WIDTH.

Behaviour:
- LEVELS = ceil(log2(SIZE)); LATENCY = max(1, LEVELS) cycles from in_valid sample to out_valid.
- Level k reduces N_k operands to ceil(N_k/2): adjacent pairs (2j, 2j+1) added, result truncated to WIDTH bits (wrap-around, no carry/saturation, no overflow flag).
- Odd operand count at a level: last operand passes through that level's register unchanged.
- SIZE=1: data_in registered once; data_out = lane 0 after 1 cycle.
- Every level's data and valid bits are registered; valid shifts alongside data through LATENCY stages.
- Fully pipelined: in_valid may be high every cycle; each accepted vector produces exactly one out_valid pulse, in order, LATENCY cycles later.
- Data registers load only when their stage valid is set; when invalid, data holds its previous value.
- out_valid low ⇒ data_out value is don't-care to consumers, but it is deterministic (held).
- Reset (rst_n low, asynchronous): all stage valids and data registers cleared to 0 immediately; out_valid=0, data_out=0. In-flight vectors are discarded, not completed.
- Reset release: first sample on the next rising edge with rst_n high; no warm-up cycles.
- All arithmetic unsigned; intermediate sums never wider than WIDTH.

Decomposition:
- No shared package typedefs needed; a constant function for ceil(log2) (clog2-equivalent, returning 0 for 1) belongs in the common utility package.
- One natural sub-module: tree_adder_level (parameters WIDTH, N_IN; N_IN operands in, ceil(N_IN/2) registered outputs plus registered valid, same clk/rst_n). tree_adder chains LEVELS instances via generate; SIZE=1 uses a single register stage.

Test Plan:
- WIDTH=8, SIZE=4, lanes 3..0 = 01,02,03,04, in_valid 1 cycle -> out_valid pulse 2 cycles later, data_out=0x0A.
- SIZE=4, all lanes 0xFF -> data_out=0xFC (1020 mod 256) after 2 cycles.
- SIZE=4, lanes = 00,00,03,02 -> 0x05; lanes = 00,00,00,05 -> 0x05; SIZE=1 build, lane 05 -> 0x05 after 1 cycle.
- Back-to-back: vectors {01,02,03,04}, {FF,FF,FF,FF}, {00,00,03,02} on consecutive cycles -> 0A, FC, 05 on consecutive cycles, out_valid high 3 cycles.
- SIZE=3 build, lanes 10,20,30 -> 0x60 after 2 cycles; SIZE=5, lanes 01..05 -> 0x0F after 3 cycles.
- Reset mid-flight: launch {01,02,03,04}, assert rst_n low between edges one cycle later -> out_valid and data_out go 0 immediately, no output pulse for that vector; after release a new vector sums correctly.

Source files
------------

// File: rtl/tree_adder_pkg.sv
// rtl/tree_adder_pkg.sv - constant helpers for sizing the reduction tree
package tree_adder_pkg;

  // Ceiling log2; a single operand needs no adder levels, so n<=1 gives 0
  function automatic int clog2_f(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r++;
    end
    return r;
  endfunction

  // Operand count entering level lvl (level 0 sees the raw lanes)
  function automatic int lanes_at(input int size, input int lvl);
    int n;
    n = size;
    for (int k = 0; k < lvl; k++) n = (n + 1) / 2;
    return n;
  endfunction

  // Lane offset of level lvl's operands inside the packed stage bus
  function automatic int lane_offset(input int size, input int lvl);
    int o;
    o = 0;
    for (int k = 0; k < lvl; k++) o += lanes_at(size, k);
    return o;
  endfunction

endpackage

// File: rtl/tree_adder_if.sv
// rtl/tree_adder_if.sv - vector-in / sum-out bundle of the reduction adder
interface tree_adder_if #(
  parameter int WIDTH = 8,
  parameter int SIZE  = 4
);
  logic                    in_valid;
  logic [WIDTH*SIZE-1:0]   data_in;
  logic                    out_valid;
  logic [WIDTH-1:0]        data_out;

  modport master (output in_valid, output data_in, input out_valid, input data_out);
  modport slave  (input in_valid, input data_in, output out_valid, output data_out);
endinterface

// File: rtl/tree_adder_level.sv
// rtl/tree_adder_level.sv - one registered pairwise-add level of the tree
module tree_adder_level
  import tree_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_IN  = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_valid,
  input  logic [N_IN*WIDTH-1:0]            i_data,
  output logic                             o_valid,
  output logic [((N_IN+1)/2)*WIDTH-1:0]    o_data
);
  localparam int N_OUT = (N_IN + 1) / 2;

  logic [N_OUT*WIDTH-1:0] w_next;
  logic [N_OUT*WIDTH-1:0] r_data;
  logic                   r_valid;

  // Adjacent pairs wrap-add at WIDTH bits; an odd trailing operand passes through
  for (genvar j = 0; j < N_OUT; j++) begin : g_pair
    if (2 * j + 1 < N_IN) begin : g_add
      assign w_next[j*WIDTH +: WIDTH] = i_data[2*j*WIDTH +: WIDTH] + i_data[(2*j+1)*WIDTH +: WIDTH];
    end else begin : g_pass
      assign w_next[j*WIDTH +: WIDTH] = i_data[2*j*WIDTH +: WIDTH];
    end
  end

  // Valid always advances; data only loads with a valid operand set, else holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) r_data <= w_next;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/tree_adder.sv
// rtl/tree_adder.sv - pipelined binary adder tree summing SIZE lanes mod 2^WIDTH
module tree_adder
  import tree_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SIZE  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  tree_adder_if.slave bus
);
  // A single lane still gets one register stage so latency is never zero
  localparam int LEVELS = clog2_f(SIZE);
  localparam int STAGES = (LEVELS == 0) ? 1 : LEVELS;
  localparam int TOTAL  = lane_offset(SIZE, STAGES + 1);

  // All stages' operands packed back to back; every slice has one driver and one reader
  logic [TOTAL*WIDTH-1:0] w_bus;
  logic [STAGES:0]        w_valid;

  assign w_bus[SIZE*WIDTH-1:0] = bus.data_in;
  assign w_valid[0]            = bus.in_valid;

  for (genvar k = 0; k < STAGES; k++) begin : g_level
    localparam int NI = lanes_at(SIZE, k);
    localparam int NO = lanes_at(SIZE, k + 1);
    localparam int OI = lane_offset(SIZE, k);
    localparam int OO = lane_offset(SIZE, k + 1);

    tree_adder_level #(
      .WIDTH (WIDTH),
      .N_IN  (NI)
    ) u_level (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (w_valid[k]),
      .i_data  (w_bus[OI*WIDTH +: NI*WIDTH]),
      .o_valid (w_valid[k+1]),
      .o_data  (w_bus[OO*WIDTH +: NO*WIDTH])
    );
  end

  assign bus.out_valid = w_valid[STAGES];
  assign bus.data_out  = w_bus[lane_offset(SIZE, STAGES)*WIDTH +: WIDTH];
endmodule

// File: tb/tb_tree_adder.sv
// tb/tb_tree_adder.sv - scoreboard bench for tree_adder at SIZE 4, 1, 3 and 5
module tb_tree_adder;
  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  exp_t q4[$];
  exp_t q1[$];
  exp_t q3[$];
  exp_t q5[$];

  tree_adder_if #(.WIDTH(8), .SIZE(4)) if4 ();
  tree_adder_if #(.WIDTH(8), .SIZE(1)) if1 ();
  tree_adder_if #(.WIDTH(8), .SIZE(3)) if3 ();
  tree_adder_if #(.WIDTH(8), .SIZE(5)) if5 ();

  tree_adder #(.WIDTH(8), .SIZE(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  tree_adder #(.WIDTH(8), .SIZE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  tree_adder #(.WIDTH(8), .SIZE(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));
  tree_adder #(.WIDTH(8), .SIZE(5)) u_dut5 (.clk(clk), .rst_n(rst_n), .bus(if5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm, input logic [7:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: out_valid with data 0x%0h but nothing expected (cycle %0d)", nm, act, cyc);
  endtask

  // Monitors: every out_valid pulse pops one expectation and checks value and arrival cycle
  always @(negedge clk) begin
    if (if4.out_valid === 1'b1) begin
      if (q4.size() == 0) unexpected("s4_spurious", if4.data_out);
      else begin
        exp_t e;
        e = q4.pop_front();
        chk("s4_data", if4.data_out, e.d);
        chk("s4_cycle", cyc, e.c);
      end
    end
    if (if1.out_valid === 1'b1) begin
      if (q1.size() == 0) unexpected("s1_spurious", if1.data_out);
      else begin
        exp_t e;
        e = q1.pop_front();
        chk("s1_data", if1.data_out, e.d);
        chk("s1_cycle", cyc, e.c);
      end
    end
    if (if3.out_valid === 1'b1) begin
      if (q3.size() == 0) unexpected("s3_spurious", if3.data_out);
      else begin
        exp_t e;
        e = q3.pop_front();
        chk("s3_data", if3.data_out, e.d);
        chk("s3_cycle", cyc, e.c);
      end
    end
    if (if5.out_valid === 1'b1) begin
      if (q5.size() == 0) unexpected("s5_spurious", if5.data_out);
      else begin
        exp_t e;
        e = q5.pop_front();
        chk("s5_data", if5.data_out, e.d);
        chk("s5_cycle", cyc, e.c);
      end
    end
  end

  // Advance to just after the next rising edge and drop all valids
  task automatic tick();
    @(posedge clk);
    #1;
    if4.in_valid = 1'b0;
    if1.in_valid = 1'b0;
    if3.in_valid = 1'b0;
    if5.in_valid = 1'b0;
  endtask

  // Each send presents a vector for the coming edge; sum appears cyc+LATENCY
  task automatic send4(input logic [31:0] v, input logic [7:0] exp);
    exp_t e;
    if4.in_valid = 1'b1;
    if4.data_in  = v;
    e.d = exp;
    e.c = cyc + 2;
    q4.push_back(e);
  endtask

  task automatic send1(input logic [7:0] v, input logic [7:0] exp);
    exp_t e;
    if1.in_valid = 1'b1;
    if1.data_in  = v;
    e.d = exp;
    e.c = cyc + 1;
    q1.push_back(e);
  endtask

  task automatic send3(input logic [23:0] v, input logic [7:0] exp);
    exp_t e;
    if3.in_valid = 1'b1;
    if3.data_in  = v;
    e.d = exp;
    e.c = cyc + 2;
    q3.push_back(e);
  endtask

  task automatic send5(input logic [39:0] v, input logic [7:0] exp);
    exp_t e;
    if5.in_valid = 1'b1;
    if5.data_in  = v;
    e.d = exp;
    e.c = cyc + 3;
    q5.push_back(e);
  endtask

  initial begin
    cyc   = 0;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    if4.in_valid = 1'b0; if4.data_in = '0;
    if1.in_valid = 1'b0; if1.data_in = '0;
    if3.in_valid = 1'b0; if3.data_in = '0;
    if5.in_valid = 1'b0; if5.data_in = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_s4_valid", if4.out_valid, 0);
    chk("rst_s4_data",  if4.data_out,  0);
    chk("rst_s1_valid", if1.out_valid, 0);
    chk("rst_s1_data",  if1.data_out,  0);
    chk("rst_s3_valid", if3.out_valid, 0);
    chk("rst_s3_data",  if3.data_out,  0);
    chk("rst_s5_valid", if5.out_valid, 0);
    chk("rst_s5_data",  if5.data_out,  0);
    rst_n = 1'b1;

    // Isolated vectors, lane 3 at the MSB end
    tick(); send4({8'h01, 8'h02, 8'h03, 8'h04}, 8'h0A);
    repeat (3) tick();
    tick(); send4({8'hFF, 8'hFF, 8'hFF, 8'hFF}, 8'hFC);
    repeat (3) tick();
    tick(); send4({8'h00, 8'h00, 8'h03, 8'h02}, 8'h05);
    tick(); send4({8'h00, 8'h00, 8'h00, 8'h05}, 8'h05);
    tick(); send4({8'h80, 8'h80, 8'h80, 8'h80}, 8'h00);
    tick(); send4({8'h40, 8'h30, 8'h20, 8'h10}, 8'hA0);
    repeat (3) tick();

    // Back-to-back stream across all builds at once
    tick();
    send4({8'h01, 8'h02, 8'h03, 8'h04}, 8'h0A);
    send1(8'h05, 8'h05);
    send3({8'h30, 8'h20, 8'h10}, 8'h60);
    send5({8'h05, 8'h04, 8'h03, 8'h02, 8'h01}, 8'h0F);
    tick();
    send4({8'hFF, 8'hFF, 8'hFF, 8'hFF}, 8'hFC);
    send1(8'hFF, 8'hFF);
    send3({8'h02, 8'hFF, 8'hFF}, 8'h00);
    send5({8'hFF, 8'h01, 8'h00, 8'h00, 8'h00}, 8'h00);
    tick();
    send4({8'h00, 8'h00, 8'h03, 8'h02}, 8'h05);
    send1(8'h00, 8'h00);
    send3({8'h00, 8'h00, 8'h07}, 8'h07);
    send5({8'h80, 8'h00, 8'h00, 8'h00, 8'h01}, 8'h81);
    repeat (5) tick();

    // Reset between edges one cycle after launch discards the in-flight sum
    tick(); send4({8'h01, 8'h02, 8'h03, 8'h04}, 8'h0A);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_s4_valid", if4.out_valid, 0);
    chk("midrst_s4_data",  if4.data_out,  0);
    chk("midrst_s5_data",  if5.data_out,  0);
    q4.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    tick(); send4({8'h11, 8'h22, 8'h33, 8'h44}, 8'hAA);
    repeat (5) tick();

    chk("drain_q4", q4.size(), 0);
    chk("drain_q1", q1.size(), 0);
    chk("drain_q3", q3.size(), 0);
    chk("drain_q5", q5.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
